slave_port: RTL

SLAVE_PORT -- requirements
Module: slave_port

---
 rtl/slave_port_pkg.sv | 26 ++
 rtl/slave_port_shift.sv | 47 ++++
 rtl/slave_port.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/slave_port_pkg.sv
// Shared bus package: master/slave port constants, slave FSM encoding and
// the address range helper used by the slave port.
package slave_port_pkg;

  localparam int MP_SEL_WIDTH  = 4;
  localparam int SP_ADDR_WIDTH = 12;
  localparam int SP_DATA_WIDTH = 8;
  localparam int SP_MEM_SIZE   = 4096;
  localparam int MP_ADDR_WIDTH = MP_SEL_WIDTH + SP_ADDR_WIDTH;

  typedef enum logic [2:0] {
    SP_IDLE    = 3'd0,
    SP_ADDR    = 3'd1,
    SP_WDATA   = 3'd2,
    SP_WRITE   = 3'd3,
    SP_RD_REQ  = 3'd4,
    SP_RD_WAIT = 3'd5,
    SP_RDATA   = 3'd6
  } sp_state_e;

  function automatic logic sp_in_range(input logic [31:0] addr,
                                       input logic [31:0] mem_size);
    return (addr < mem_size);
  endfunction

endpackage

// File: rtl/slave_port_shift.sv
// LSB-first shift register: serial-in/parallel-out and parallel-in/serial-out
// with a count of bits shifted since the last load or restart.
module slave_port_shift #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_restart,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_shifted,
  output logic             o_last
);

  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_base;
  logic [CW-1:0]    w_count_base;

  // o_shifted is the register contents after this cycle's shift, so the
  // parent can capture a completed word on the same edge as its last bit.
  always_comb begin
    w_base       = i_restart ? '0 : r_data;
    w_count_base = i_restart ? '0 : r_count;
    o_shifted    = w_base >> 1;
    o_shifted[WIDTH-1] = i_bit;
  end

  assign o_last = (w_count_base == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_count <= '0;
    end else if (i_shift) begin
      r_data  <= o_shifted;
      r_count <= w_count_base + CW'(1);
    end
  end

endmodule

// File: rtl/slave_port.sv
// Serial slave port: LSB-first address/data frames mapped onto a synchronous memory.
// Define SLAVE_PORT_ABORT_EN to make mvalid=0 during ADDR/WDATA abort the frame.
//
// state      | meaning
// IDLE       | sready=1, waiting for first address bit
// ADDR       | shifting in remaining address bits
// WDATA      | shifting in write data bits
// WRITE      | mem_wen pulse (suppressed when out of range)
// RD_REQ     | mem_ren pulse (suppressed when out of range)
// RD_WAIT    | memory read latency, capture mem_rdata
// RDATA      | shifting out read data, svalid=1
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
  parameter int DATA_WIDTH = SP_DATA_WIDTH,
  parameter int MEM_SIZE   = SP_MEM_SIZE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef SLAVE_PORT_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  sp_state_e             r_state;
  logic                  r_mode;
  logic                  r_in_range;
  logic                  r_srdata;
  logic                  r_svalid;
  logic                  r_sready;
  logic                  r_mem_wen;
  logic                  r_mem_ren;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                  w_addr_shift;
  logic                  w_addr_restart;
  logic                  w_addr_last;
  logic                  w_addr_done;
  logic                  w_addr_ok;
  logic                  w_mode;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  w_data_shift;
  logic                  w_data_load;
  logic                  w_data_last;
  logic [DATA_WIDTH-1:0] w_data_load_val;
  logic [DATA_WIDTH-1:0] w_data_next;

  always_comb begin
    w_addr_restart  = (r_state == SP_IDLE);
    w_addr_shift    = mvalid && ((r_state == SP_IDLE) || (r_state == SP_ADDR));
    w_addr_done     = w_addr_shift && w_addr_last;
    w_mode          = (r_state == SP_IDLE) ? smode : r_mode;
    w_addr_ok       = sp_in_range(32'(w_addr_next), 32'(MEM_SIZE));
    w_data_load     = (w_addr_done && w_mode) || (r_state == SP_RD_WAIT);
    w_data_load_val = ((r_state == SP_RD_WAIT) && r_in_range) ? mem_rdata : '0;
    w_data_shift    = ((r_state == SP_WDATA) && mvalid) || (r_state == SP_RDATA);
  end

  slave_port_shift #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk         (clk),
    .rstn        (rstn),
    .i_restart   (w_addr_restart),
    .i_shift     (w_addr_shift),
    .i_bit       (swdata),
    .i_load      (1'b0),
    .i_load_data ('0),
    .o_shifted   (w_addr_next),
    .o_last      (w_addr_last)
  );

  slave_port_shift #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk         (clk),
    .rstn        (rstn),
    .i_restart   (1'b0),
    .i_shift     (w_data_shift),
    .i_bit       (swdata),
    .i_load      (w_data_load),
    .i_load_data (w_data_load_val),
    .o_shifted   (w_data_next),
    .o_last      (w_data_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= SP_IDLE;
      r_mode      <= 1'b0;
      r_in_range  <= 1'b0;
      r_srdata    <= 1'b0;
      r_svalid    <= 1'b0;
      r_sready    <= 1'b1;
      r_mem_wen   <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        SP_IDLE: begin
          if (mvalid) begin
            r_mode   <= smode;
            r_sready <= 1'b0;
            r_state  <= SP_ADDR;
          end
        end
        SP_ADDR: begin
          if (!mvalid && ABORT_EN) begin
            r_state  <= SP_IDLE;
            r_sready <= 1'b1;
          end
        end
        SP_WDATA: begin
          if (mvalid) begin
            if (w_data_last) begin
              r_mem_wdata <= w_data_next;
              r_mem_wen   <= r_in_range;
              r_state     <= SP_WRITE;
            end
          end else if (ABORT_EN) begin
            r_state  <= SP_IDLE;
            r_sready <= 1'b1;
          end
        end
        SP_WRITE: begin
          r_mem_wen <= 1'b0;
          r_sready  <= 1'b1;
          r_state   <= SP_IDLE;
        end
        SP_RD_REQ: begin
          r_mem_ren <= 1'b0;
          r_state   <= SP_RD_WAIT;
        end
        SP_RD_WAIT: begin
          r_srdata <= r_in_range & mem_rdata[0];
          r_svalid <= 1'b1;
          r_state  <= SP_RDATA;
        end
        SP_RDATA: begin
          if (w_data_last) begin
            r_srdata <= 1'b0;
            r_svalid <= 1'b0;
            r_sready <= 1'b1;
            r_state  <= SP_IDLE;
          end else begin
            r_srdata <= w_data_next[0];
          end
        end
        default: begin
          r_srdata  <= 1'b0;
          r_svalid  <= 1'b0;
          r_mem_wen <= 1'b0;
          r_mem_ren <= 1'b0;
          r_sready  <= 1'b1;
          r_state   <= SP_IDLE;
        end
      endcase

      // Address completion can happen from IDLE (1-bit address) or ADDR.
      if (w_addr_done) begin
        r_mem_addr <= w_addr_next;
        r_in_range <= w_addr_ok;
        if (w_mode) begin
          r_state <= SP_WDATA;
        end else begin
          r_mem_ren <= w_addr_ok;
          r_state   <= SP_RD_REQ;
        end
      end
    end
  end

  assign srdata    = r_srdata;
  assign svalid    = r_svalid;
  assign sready    = r_sready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wen   = r_mem_wen;
  assign mem_ren   = r_mem_ren;

endmodule
